mem_line_arbiter: RTL and testbench
===================================

# mem_line_arbiter

Two-port round-robin arbiter that shares one wide line-fill memory read port between two cache refill requesters. Port 0 is the instruction cache refill port; port 1 is a second refill client, such as a data cache or a prefetcher. The block sits between the caches' `mem_req_*` interfaces and the backing memory. It serializes line fetches, line-aligns addresses and routes the returned line to the winning requester. It also keeps per-port grant counters for performance debug.

## Interface
Parameters:
- `NUM_BLOCKS`, 4: 32-bit words per line; the line width is 32*NUM_BLOCKS bits.
- `BLOCK_SIZE`, 4: bytes per word; together with NUM_BLOCKS this sets the number of forced-zero address bits.
- `CNT_BITS`, 16: width of each grant counter.

Ports:
- `clk`  in  1  clock.
- `resetn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  2  per-port fill request, held high until that port sees `req_ready`.
- `req_addr0`, `req_addr1`  in  32  per-port fill address.
- `req_ready`  out  2  per-port one-cycle completion pulse; line is valid on `req_rdata` in the same cycle.
- `req_rdata`  out  32*NUM_BLOCKS  returned line, shared by both ports.
- `mem_valid`  out  1  request to backing memory.
- `mem_ready`  in  1  one-cycle pulse from memory; `mem_rdata` is valid in that cycle.
- `mem_addr`  out  32  line-aligned address.
- `mem_rdata`  in  32*NUM_BLOCKS  line from memory.
- `grant_cnt0`, `grant_cnt1`  out  CNT_BITS  completed grants per port, wrapping.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE:**
  - Sample `req_valid`. If exactly one bit is set, that port wins.
  - If both bits are set, the port not in `last_grant` wins.
  - On a win: latch `gnt`. Latch `mem_addr` as the winner's address with its low log2(NUM_BLOCKS)+log2(BLOCK_SIZE) bits forced to 0.
  - Set `mem_valid`<=1, set `last_grant`<=winner, and go to BUSY.
- **BUSY:**
  - Hold `mem_valid` and `mem_addr` stable.
  - When `mem_ready`=1:
    - Set `mem_valid`<=0 and `req_rdata`<=`mem_rdata`.
    - If `req_valid[gnt]` is still 1: set `req_ready[gnt]`<=1 and increment `grant_cnt[gnt]`.
    - Go to DONE.
- **DONE:**
  - Set `req_ready`<=0 and return to IDLE.
  - DONE gives the requester the edge it needs to drop `req_valid` before re-arbitration.
- **Abandoned request:** if the granted port drops `req_valid` during BUSY, the memory transaction still completes. No `req_ready` is pulsed, the counter is not incremented, and `last_grant` keeps its updated value.
- `mem_ready` is ignored outside BUSY.
- `req_rdata` is undefined except when `req_ready` is high.
- The ungranted port's `req_valid` may stay high throughout; it is served at the next IDLE.
- Counters wrap modulo 2^CNT_BITS.

## Timing
- **Reset values:**
  - All outputs are 0 (`req_ready`, `req_rdata`, `mem_valid`, `mem_addr`, `grant_cnt0/1`, `busy`).
  - State is IDLE.
  - `last_grant`=1, so port 0 wins the first tie.
- **Reset mid-operation:** reset is honoured in any state. The FSM returns to IDLE with `mem_valid`=0 on the next cycle, and a pending memory response is dropped.
- **Latency:**
  - A request sampled in IDLE in cycle t drives `mem_valid` high in cycle t+1.
  - If `mem_ready` is high in cycle k (k ≥ t+1), `req_ready` pulses in cycle k+1 and `mem_valid` is low in cycle k+1.
  - The FSM is in IDLE in cycle k+2.
- **Minimum cost:** 3 cycles per transaction plus memory wait. Back-to-back grants are separated by one DONE cycle.
- **Memory contract:** memory pulses `mem_ready` for exactly one cycle per `mem_valid` assertion.
- **Requester contract:** a requester drops `req_valid` on the edge after its `req_ready` pulse.

## Test plan
- **Single request:** port0 requests 0x0000_1234 and memory answers in 3 cycles with line 0xA..D → `mem_addr`=0x0000_1230; `req_ready`=2'b01 exactly once, 4 cycles after `mem_valid` rises; `req_rdata` matches; `grant_cnt0`=1.
- **Simultaneous requests after reset:** both ports request 0x100 and 0x200 → port0 served first (`mem_addr`=0x100), then port1 (0x200), with exactly one DONE/IDLE gap between the grants.
- **Fairness under contention:** both ports continuously re-request for 10 transactions → grants alternate 0,1,0,1…; `grant_cnt0`=`grant_cnt1`=5.
- **Abandoned request:** port1 drops `req_valid` in BUSY before `mem_ready` → no `req_ready` pulse; `grant_cnt1` is unchanged; the FSM returns to IDLE and a following port1 request is serviced normally.
- **Reset mid-transaction:** assert `resetn`=0 during BUSY, then `mem_ready` pulses → all outputs are 0 on the next cycle; no `req_ready`; the first tie after reset goes to port0.
- **Counter wrap:** with CNT_BITS=2, five grants on port0 → `grant_cnt0`=1.

Source files
------------

// File: rtl/mem_line_arbiter.sv
// Round-robin arbiter sharing one line-fill memory read port between two cache refill requesters.
// Grant->mem_valid 1 cycle, mem_ready->req_ready 1 cycle, then one DONE cycle; requests simply wait while busy.
module mem_line_arbiter #(
    parameter int NUM_BLOCKS = 4,
    parameter int BLOCK_SIZE = 4,
    parameter int CNT_BITS   = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [1:0]              req_valid,
    input  logic [31:0]             req_addr0,
    input  logic [31:0]             req_addr1,
    output logic [1:0]              req_ready,
    output logic [32*NUM_BLOCKS-1:0] req_rdata,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [31:0]             mem_addr,
    input  logic [32*NUM_BLOCKS-1:0] mem_rdata,
    output logic [CNT_BITS-1:0]     grant_cnt0,
    output logic [CNT_BITS-1:0]     grant_cnt1,
    output logic                    busy
);

    localparam int          LINE_W    = 32 * NUM_BLOCKS;
    localparam int          OFFS_W    = $clog2(NUM_BLOCKS) + $clog2(BLOCK_SIZE);
    localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFS_W) - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                gnt_q, gnt_d;
    logic                last_grant_q, last_grant_d;
    logic                mem_valid_q, mem_valid_d;
    logic [31:0]         mem_addr_q, mem_addr_d;
    logic [1:0]          req_ready_q, req_ready_d;
    logic [LINE_W-1:0]   req_rdata_q, req_rdata_d;
    logic [CNT_BITS-1:0] grant_cnt0_q, grant_cnt0_d;
    logic [CNT_BITS-1:0] grant_cnt1_q, grant_cnt1_d;
    logic                win;
    logic [31:0]         win_addr;

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        mem_valid_d  = mem_valid_q;
        mem_addr_d   = mem_addr_q;
        req_ready_d  = req_ready_q;
        req_rdata_d  = req_rdata_q;
        grant_cnt0_d = grant_cnt0_q;
        grant_cnt1_d = grant_cnt1_q;
        // On a tie the port that did not win last time goes first.
        win          = (req_valid == 2'b11) ? ~last_grant_q : req_valid[1];
        win_addr     = win ? req_addr1 : req_addr0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid != 2'b00) begin
                    gnt_d        = win;
                    last_grant_d = win;
                    mem_valid_d  = 1'b1;
                    mem_addr_d   = win_addr & LINE_MASK;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    req_rdata_d = mem_rdata;
                    state_d     = ST_DONE;
                    // A requester that gave up still lets the memory beat drain, but earns no credit.
                    if (req_valid[gnt_q]) begin
                        req_ready_d[gnt_q] = 1'b1;
                        if (gnt_q) begin
                            grant_cnt1_d = grant_cnt1_q + CNT_BITS'(1);
                        end else begin
                            grant_cnt0_d = grant_cnt0_q + CNT_BITS'(1);
                        end
                    end
                end
            end
            ST_DONE: begin
                req_ready_d = 2'b00;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_IDLE;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_addr_q   <= '0;
            req_ready_q  <= 2'b00;
            req_rdata_q  <= '0;
            grant_cnt0_q <= '0;
            grant_cnt1_q <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            mem_valid_q  <= mem_valid_d;
            mem_addr_q   <= mem_addr_d;
            req_ready_q  <= req_ready_d;
            req_rdata_q  <= req_rdata_d;
            grant_cnt0_q <= grant_cnt0_d;
            grant_cnt1_q <= grant_cnt1_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign req_rdata  = req_rdata_q;
    assign mem_valid  = mem_valid_q;
    assign mem_addr   = mem_addr_q;
    assign grant_cnt0 = grant_cnt0_q;
    assign grant_cnt1 = grant_cnt1_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_line_arbiter.sv
// Bench for mem_line_arbiter: transaction-level model compared every cycle plus hand-computed literals.
module tb_mem_line_arbiter;

    localparam int  LINE_BYTES = 16;
    localparam int  CNT_MOD    = 65536;

    logic         clk = 1'b0;
    logic         resetn;
    logic [1:0]   req_valid;
    logic [31:0]  req_addr0, req_addr1;
    logic [1:0]   req_ready;
    logic [127:0] req_rdata;
    logic         mem_valid;
    logic         mem_ready;
    logic [31:0]  mem_addr;
    logic [127:0] mem_rdata;
    logic [15:0]  grant_cnt0, grant_cnt1;
    logic         busy;

    logic [1:0]   w_req_valid;
    logic [31:0]  w_req_addr0, w_req_addr1;
    logic [1:0]   w_req_ready;
    logic [127:0] w_req_rdata;
    logic         w_mem_valid;
    logic         w_mem_ready;
    logic [31:0]  w_mem_addr;
    logic [127:0] w_mem_rdata;
    logic [1:0]   w_grant_cnt0, w_grant_cnt1;
    logic         w_busy;

    always #5 clk = ~clk;

    mem_line_arbiter dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_ready(req_ready), .req_rdata(req_rdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .busy(busy)
    );

    mem_line_arbiter #(.NUM_BLOCKS(4), .BLOCK_SIZE(4), .CNT_BITS(2)) dut_w (
        .clk(clk), .resetn(resetn),
        .req_valid(w_req_valid), .req_addr0(w_req_addr0), .req_addr1(w_req_addr1),
        .req_ready(w_req_ready), .req_rdata(w_req_rdata),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready), .mem_addr(w_mem_addr), .mem_rdata(w_mem_rdata),
        .grant_cnt0(w_grant_cnt0), .grant_cnt1(w_grant_cnt1), .busy(w_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Transaction-level model: one fetch in flight, then a completion cycle.
    logic         m_inflight = 1'b0;
    logic         m_done     = 1'b0;
    logic [1:0]   m_pulse    = 2'b00;
    logic         m_last     = 1'b1;
    logic         m_owner    = 1'b0;
    logic         m_who;
    logic [31:0]  m_addr     = 32'd0;
    logic [127:0] m_line     = '0;
    int           m_cnt [2]  = '{0, 0};

    always @(posedge clk) begin
        if (!resetn) begin
            m_inflight <= 1'b0;
            m_done     <= 1'b0;
            m_pulse    <= 2'b00;
            m_last     <= 1'b1;
            m_cnt[0]   <= 0;
            m_cnt[1]   <= 0;
        end else if (m_inflight) begin
            if (mem_ready) begin
                m_inflight <= 1'b0;
                m_done     <= 1'b1;
                m_line     <= mem_rdata;
                if (req_valid[m_owner]) begin
                    m_pulse[m_owner] <= 1'b1;
                    m_cnt[m_owner]   <= (m_cnt[m_owner] + 1) % CNT_MOD;
                end
            end
        end else if (m_done) begin
            m_done  <= 1'b0;
            m_pulse <= 2'b00;
        end else if (req_valid != 2'b00) begin
            if (req_valid == 2'b01)      m_who = 1'b0;
            else if (req_valid == 2'b10) m_who = 1'b1;
            else                         m_who = (m_last == 1'b0);
            m_owner    <= m_who;
            m_last     <= m_who;
            m_inflight <= 1'b1;
            m_addr     <= ((m_who ? req_addr1 : req_addr0) / LINE_BYTES) * LINE_BYTES;
        end
    end

    always @(negedge clk) begin
        check("mem_valid", {127'd0, mem_valid}, {127'd0, m_inflight});
        check("busy", {127'd0, busy}, {127'd0, m_inflight | m_done});
        check("req_ready", {126'd0, req_ready}, {126'd0, m_pulse});
        check("grant_cnt0", {112'd0, grant_cnt0}, 128'(m_cnt[0]));
        check("grant_cnt1", {112'd0, grant_cnt1}, 128'(m_cnt[1]));
        if (m_inflight) check("mem_addr", {96'd0, mem_addr}, {96'd0, m_addr});
        if (m_pulse != 2'b00) check("req_rdata", req_rdata, m_line);
    end

    // Requester and memory agents, run once per negedge from step().
    int           cyc = 0;
    int           want [2];
    int           mem_lat = 3;
    int           mem_wait = 0;
    bit           auto_mem = 1'b1;
    logic         prev_mv = 1'b0;
    int           grant_log [$];
    int           rr_cyc_log [$];
    int           mv_cyc_log [$];
    logic [31:0]  addr_log [$];
    logic [127:0] rd_log [$];

    task automatic step();
        @(negedge clk);
        cyc++;
        if (mem_valid && !prev_mv) begin
            mv_cyc_log.push_back(cyc);
            addr_log.push_back(mem_addr);
        end
        prev_mv = mem_valid;
        for (int p = 0; p < 2; p++) begin
            if (req_ready[p]) begin
                grant_log.push_back(p);
                rr_cyc_log.push_back(cyc);
                rd_log.push_back(req_rdata);
                req_valid[p] = 1'b0;
                if (want[p] > 0) want[p]--;
            end else if (want[p] > 0 && !req_valid[p]) begin
                req_valid[p] = 1'b1;
            end
        end
        if (auto_mem) begin
            if (mem_ready) begin
                mem_ready = 1'b0;
            end else if (mem_valid) begin
                if (mem_wait == mem_lat) begin
                    mem_ready = 1'b1;
                    mem_rdata = {mem_addr | 32'hD, mem_addr | 32'hC, mem_addr | 32'hB, mem_addr | 32'hA};
                    mem_wait  = 0;
                end else begin
                    mem_wait++;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        step();
        while ((want[0] != 0 || want[1] != 0 || busy || req_valid != 2'b00) && n < budget) begin
            step();
            n++;
        end
        check(name, {127'd0, n < budget}, 128'd1);
    endtask

    task automatic clear_logs();
        grant_log.delete(); rr_cyc_log.delete(); mv_cyc_log.delete();
        addr_log.delete(); rd_log.delete();
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        step(); step();
        resetn = 1'b1;
        step();
    endtask

    task automatic wrap_txn(input int idx);
        int n = 0;
        w_req_valid = 2'b01;
        step();
        while (!w_mem_valid && n < 20) begin step(); n++; end
        check($sformatf("wrap%0d_mem_valid", idx), {127'd0, w_mem_valid}, 128'd1);
        check($sformatf("wrap%0d_mem_addr", idx), {96'd0, w_mem_addr}, 128'h50);
        w_mem_ready = 1'b1;
        step();
        w_mem_ready = 1'b0;
        check($sformatf("wrap%0d_req_ready", idx), {126'd0, w_req_ready}, 128'd1);
        w_req_valid = 2'b00;
        step();
        step();
    endtask

    initial begin
        resetn = 1'b0; req_valid = 2'b00; req_addr0 = 32'd0; req_addr1 = 32'd0;
        mem_ready = 1'b0; mem_rdata = '0; want[0] = 0; want[1] = 0;
        w_req_valid = 2'b00; w_req_addr0 = 32'h55; w_req_addr1 = 32'd0;
        w_mem_ready = 1'b0; w_mem_rdata = 128'hCAFE;
        repeat (3) step();

        check("rst_mem_valid", {127'd0, mem_valid}, 128'd0);
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_req_ready", {126'd0, req_ready}, 128'd0);
        check("rst_mem_addr", {96'd0, mem_addr}, 128'd0);
        check("rst_req_rdata", req_rdata, 128'd0);
        check("rst_cnt", {96'd0, grant_cnt0, grant_cnt1}, 128'd0);
        resetn = 1'b1;
        step();

        // Single request with a 3-cycle memory.
        clear_logs();
        req_addr0 = 32'h0000_1234; mem_lat = 3; want[0] = 1;
        wait_idle("t1_idle", 200);
        check("t1_grants", 128'(grant_log.size()), 128'd1);
        check("t1_port", 128'(grant_log[0]), 128'd0);
        check("t1_mem_addr", {96'd0, addr_log[0]}, 128'h1230);
        check("t1_latency", 128'(rr_cyc_log[0] - mv_cyc_log[0]), 128'd4);
        check("t1_rdata", rd_log[0], 128'h0000123D_0000123C_0000123B_0000123A);
        check("t1_cnt0", {112'd0, grant_cnt0}, 128'd1);

        // Tie right after port 0 won: port 1 goes first.
        clear_logs();
        req_addr0 = 32'h7777_7777; req_addr1 = 32'h0000_ABCF; mem_lat = 0;
        want[0] = 1; want[1] = 1;
        wait_idle("t2_idle", 200);
        check("t2_first", 128'(grant_log[0]), 128'd1);
        check("t2_second", 128'(grant_log[1]), 128'd0);
        check("t2_addr", {96'd0, addr_log[0]}, 128'hABC0);

        // Simultaneous requests after reset.
        do_reset();
        clear_logs();
        req_addr0 = 32'h100; req_addr1 = 32'h200; mem_lat = 2;
        want[0] = 1; want[1] = 1;
        wait_idle("t3_idle", 200);
        check("t3_addr0", {96'd0, addr_log[0]}, 128'h100);
        check("t3_addr1", {96'd0, addr_log[1]}, 128'h200);
        check("t3_gap", 128'(mv_cyc_log[1] - rr_cyc_log[0]), 128'd2);

        // Fairness under sustained contention.
        do_reset();
        clear_logs();
        mem_lat = 1; want[0] = 5; want[1] = 5;
        wait_idle("t4_idle", 400);
        check("t4_grants", 128'(grant_log.size()), 128'd10);
        for (int i = 0; i < 10; i++) check($sformatf("t4_order%0d", i), 128'(grant_log[i]), 128'(i % 2));
        check("t4_cnt0", {112'd0, grant_cnt0}, 128'd5);
        check("t4_cnt1", {112'd0, grant_cnt1}, 128'd5);

        // Port 1 abandons its request while the fetch is outstanding.
        clear_logs();
        auto_mem = 1'b0;
        req_addr1 = 32'h3333_3338; req_valid = 2'b10;
        step(); step();
        check("t5_mem_valid", {127'd0, mem_valid}, 128'd1);
        check("t5_mem_addr", {96'd0, mem_addr}, 128'h33333330);
        req_valid = 2'b00;
        step();
        mem_ready = 1'b1; mem_rdata = 128'hDEAD;
        step();
        mem_ready = 1'b0;
        check("t5_no_ready", {126'd0, req_ready}, 128'd0);
        wait_idle("t5_idle", 50);
        check("t5_no_grant", 128'(grant_log.size()), 128'd0);
        check("t5_cnt1", {112'd0, grant_cnt1}, 128'd5);
        auto_mem = 1'b1; mem_lat = 1; want[1] = 1;
        wait_idle("t5_retry_idle", 200);
        check("t5_retry_port", 128'(grant_log[0]), 128'd1);
        check("t5_retry_cnt1", {112'd0, grant_cnt1}, 128'd6);

        // Reset while BUSY, with the memory answering during and after reset.
        clear_logs();
        auto_mem = 1'b0;
        req_addr0 = 32'h40; req_valid = 2'b01;
        step(); step();
        check("t6_busy", {127'd0, busy}, 128'd1);
        resetn = 1'b0; req_valid = 2'b00; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        check("t6_mem_valid", {127'd0, mem_valid}, 128'd0);
        check("t6_outs", {busy, req_ready, grant_cnt0, grant_cnt1, mem_addr}, 128'd0);
        check("t6_rdata", req_rdata, 128'd0);
        resetn = 1'b1; mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        step();
        check("t6_stray_ready", {125'd0, busy, req_ready}, 128'd0);
        auto_mem = 1'b1; req_addr0 = 32'h500; req_addr1 = 32'h600;
        want[0] = 1; want[1] = 1;
        wait_idle("t6_idle", 200);
        check("t6_tie_first", 128'(grant_log[0]), 128'd0);
        check("t6_tie_second", 128'(grant_log[1]), 128'd1);

        // Counter wrap on the 2-bit instance.
        for (int i = 0; i < 5; i++) begin
            wrap_txn(i);
            if (i == 0) check("wrap_rdata", w_req_rdata, 128'hCAFE);
            if (i == 3) check("wrap_cnt_at4", {126'd0, w_grant_cnt0}, 128'd0);
        end
        check("wrap_cnt0", {126'd0, w_grant_cnt0}, 128'd1);
        check("wrap_cnt1", {126'd0, w_grant_cnt1}, 128'd0);
        check("wrap_busy", {127'd0, w_busy}, 128'd0);

        step();
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
